// File: rtl/sram_port_arbiter.sv
// Shares one fixed-latency single-port SRAM between fetch and the memory stage.
// Optional SRAM_ARB_ROUND_ROBIN_EN: alternate grants on simultaneous requests.
module sram_port_arbiter #(
  parameter int WORD_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int WAIT_CYCLES = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [WORD_WIDTH-1:0] if_addr,
  output logic [WORD_WIDTH-1:0] if_rdata,
  output logic                  if_ready,
  output logic                  if_stall,
  input  logic                  mem_rd_req,
  input  logic                  mem_wr_req,
  input  logic [WORD_WIDTH-1:0] mem_addr,
  input  logic [WORD_WIDTH-1:0] mem_wdata,
  output logic [WORD_WIDTH-1:0] mem_rdata,
  output logic                  mem_ready,
  output logic                  mem_stall,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [WORD_WIDTH-1:0] sram_wdata,
  output logic                  sram_we,
  output logic                  sram_oe,
  input  logic [WORD_WIDTH-1:0] sram_rdata
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_IF   = 2'd1;
  localparam logic [1:0] GNT_MEM  = 2'd2;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  logic [1:0]            state_q, state_d;
  logic [1:0]            grant_q, grant_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic [WORD_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [WORD_WIDTH-1:0] mem_rdata_q, mem_rdata_d;

  logic mem_any;
  logic pick_mem;
  logic access;

  assign mem_any = mem_rd_req | mem_wr_req;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic last_mem_q, last_mem_d;
  // On a tie MEM wins unless it was the requester served most recently
  assign pick_mem = mem_any && !(if_req && last_mem_q);
`else
  assign pick_mem = mem_any;
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    last_mem_d  = last_mem_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (mem_any || if_req) begin
          state_d = ST_ACCESS;
          cnt_d   = CNT_LOAD;
          if (pick_mem) begin
            grant_d = GNT_MEM;
            addr_d  = mem_addr[ADDR_WIDTH+1:2];
            wdata_d = mem_wdata;
            write_d = mem_wr_req;
          end else begin
            grant_d = GNT_IF;
            addr_d  = if_addr[ADDR_WIDTH+1:2];
            wdata_d = '0;
            write_d = 1'b0;
          end
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
          if (!write_q) begin
            if (grant_q == GNT_MEM) mem_rdata_d = sram_rdata;
            else                    if_rdata_d  = sram_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        grant_d = GNT_NONE;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        last_mem_d = (grant_q == GNT_MEM);
`endif
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = GNT_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= GNT_NONE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      last_mem_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      last_mem_q  <= last_mem_d;
`endif
    end
  end

  // SRAM bus is driven only while a transaction is in ACCESS
  assign access     = (state_q == ST_ACCESS);
  assign sram_addr  = access ? addr_q : '0;
  assign sram_wdata = access ? wdata_q : '0;
  assign sram_we    = access && write_q;
  assign sram_oe    = access && !write_q;

  assign if_ready  = (state_q == ST_DONE) && (grant_q == GNT_IF);
  assign mem_ready = (state_q == ST_DONE) && (grant_q == GNT_MEM);
  assign if_stall  = if_req && !if_ready;
  assign mem_stall = mem_any && !mem_ready;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[1:0], if_addr[WORD_WIDTH-1:ADDR_WIDTH+2],
                              mem_addr[1:0], mem_addr[WORD_WIDTH-1:ADDR_WIDTH+2]};

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter with a simple behavioural SRAM.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        if_stall;
  logic        mem_rd_req;
  logic        mem_wr_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_stall;
  logic [15:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        sram_we;
  logic        sram_oe;
  logic [31:0] sram_rdata;

  sram_port_arbiter #(
    .WORD_WIDTH (32),
    .ADDR_WIDTH (16),
    .WAIT_CYCLES(5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .if_stall  (if_stall),
    .mem_rd_req(mem_rd_req),
    .mem_wr_req(mem_wr_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .mem_stall (mem_stall),
    .sram_addr (sram_addr),
    .sram_wdata(sram_wdata),
    .sram_we   (sram_we),
    .sram_oe   (sram_oe),
    .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: combinational read, write on the clock edge
  logic [31:0] mem_arr [0:255];
  assign sram_rdata = mem_arr[sram_addr[7:0]];
  always @(posedge clk) if (sram_we) mem_arr[sram_addr[7:0]] <= sram_wdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    bit          chk_data;
    int          due;
  } sb_t;

  sb_t if_q[$];
  sb_t mem_q[$];

  int errors = 0;
  int checks = 0;
  int oe_cnt, we_cnt, ifst_cnt;
  logic [15:0] last_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clr_counters();
    oe_cnt = 0; we_cnt = 0; ifst_cnt = 0; last_addr = '0;
  endtask

  // Monitor: strobe bookkeeping and scoreboard pops on ready pulses
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (sram_oe) oe_cnt++;
        if (sram_we) we_cnt++;
        if (sram_oe || sram_we) last_addr = sram_addr;
        if (if_stall) ifst_cnt++;
        if (if_ready) begin
          if (if_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL if_ready unexpected: got 1 expected 0 (cycle %0d)", cyc);
          end else begin
            e = if_q.pop_front();
            chk("if_ready cycle", cyc, e.due);
            if (e.chk_data) chk("if_rdata", if_rdata, e.rdata);
          end
        end
        if (mem_ready) begin
          if (mem_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL mem_ready unexpected: got 1 expected 0 (cycle %0d)", cyc);
          end else begin
            e = mem_q.pop_front();
            chk("mem_ready cycle", cyc, e.due);
            if (e.chk_data) chk("mem_rdata", mem_rdata, e.rdata);
          end
        end
      end
    end
  end

  // Callers start these at #1 after a rising edge; they return likewise aligned
  task automatic if_txn(input logic [31:0] addr, input logic [31:0] exp, input int lat);
    sb_t e;
    bit  seen;
    if_req  = 1'b1;
    if_addr = addr;
    e.rdata = exp; e.chk_data = 1'b1; e.due = cyc + lat;
    if_q.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = if_ready;
    end
    chk("if_ready seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic mem_txn(input bit wr, input bit rd, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp,
                         input bit chk_data, input int lat);
    sb_t e;
    bit  seen;
    mem_wr_req = wr;
    mem_rd_req = rd;
    mem_addr   = addr;
    mem_wdata  = wdata;
    e.rdata = exp; e.chk_data = chk_data; e.due = cyc + lat;
    mem_q.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = mem_ready;
    end
    chk("mem_ready seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
    mem_wr_req = 1'b0;
    mem_rd_req = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " if_rdata"}, if_rdata, 32'h0);
    chk({tag, " mem_rdata"}, mem_rdata, 32'h0);
    chk({tag, " ready/stall/strobes"},
        {26'h0, if_ready, if_stall, mem_ready, mem_stall, sram_we, sram_oe}, 32'h0);
    chk({tag, " sram_addr"}, 32'(sram_addr), 32'h0);
    chk({tag, " sram_wdata"}, sram_wdata, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    sb_t e;
    bit  seen;
    for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
    mem_arr[8'h04] = 32'hE3A0_0001;
    mem_arr[8'h20] = 32'h1111_1111;
    mem_arr[8'h30] = 32'h2222_2222;
    rst = 1'b1; if_req = 1'b0; if_addr = '0;
    mem_rd_req = 1'b0; mem_wr_req = 1'b0; mem_addr = '0; mem_wdata = '0;
    clr_counters();

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_idle_outputs("reset");
    @(posedge clk); #1;

    // IF read of word 4
    clr_counters();
    if_txn(32'h0000_0010, 32'hE3A0_0001, 6);
    chk("t1 oe cycles", 32'(oe_cnt), 32'd5);
    chk("t1 we cycles", 32'(we_cnt), 32'd0);
    chk("t1 sram_addr", 32'(last_addr), 32'h4);
    chk("t1 if_stall cycles", 32'(ifst_cnt), 32'd6);

    // MEM write then IF read-back
    clr_counters();
    mem_txn(1'b1, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 1'b0, 6);
    chk("t2 we cycles", 32'(we_cnt), 32'd5);
    chk("t2 oe cycles", 32'(oe_cnt), 32'd0);
    chk("t2 sram_addr", 32'(last_addr), 32'h40);
    if_txn(32'h0000_0100, 32'hDEAD_BEEF, 6);

    // Tie after IF was last served: MEM first in both builds
    fork
      if_txn(32'h0000_0080, 32'h1111_1111, 13);
      mem_txn(1'b0, 1'b1, 32'h0000_00C0, 32'h0, 32'h2222_2222, 1'b1, 6);
    join

    // Tie after MEM was last served
    mem_txn(1'b0, 1'b1, 32'h0000_00C0, 32'h0, 32'h2222_2222, 1'b1, 6);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    fork
      if_txn(32'h0000_0080, 32'h1111_1111, 6);
      mem_txn(1'b0, 1'b1, 32'h0000_00C0, 32'h0, 32'h2222_2222, 1'b1, 13);
    join
`else
    fork
      if_txn(32'h0000_0080, 32'h1111_1111, 13);
      mem_txn(1'b0, 1'b1, 32'h0000_00C0, 32'h0, 32'h2222_2222, 1'b1, 6);
    join
`endif

    // Read and write requested together: behaves as a write
    clr_counters();
    mem_txn(1'b1, 1'b1, 32'h0000_0200, 32'hCAFE_F00D, 32'h0, 1'b0, 6);
    chk("t4 oe cycles", 32'(oe_cnt), 32'd0);
    chk("t4 we cycles", 32'(we_cnt), 32'd5);
    if_txn(32'h0000_0200, 32'hCAFE_F00D, 6);

    // Reset during ACCESS cycle 3 of a write: no ready pulse afterwards
    mem_wr_req = 1'b1; mem_addr = 32'h0000_0300; mem_wdata = 32'h1234_5678;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1; mem_wr_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_idle_outputs("midrst");
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
    if_txn(32'h0000_0010, 32'hE3A0_0001, 6);

    // IF withdraws in ACCESS cycle 2 while MEM becomes pending
    if_req = 1'b1; if_addr = 32'h0000_0010;
    e.rdata = 32'hE3A0_0001; e.chk_data = 1'b1; e.due = cyc + 6;
    if_q.push_back(e);
    repeat (2) begin @(posedge clk); #1; end
    if_req = 1'b0;
    mem_rd_req = 1'b1; mem_addr = 32'h0000_00C0;
    e.rdata = 32'h2222_2222; e.chk_data = 1'b1; e.due = cyc + 11;
    mem_q.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = mem_ready;
    end
    chk("t6 mem_ready seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
    mem_rd_req = 1'b0;
    repeat (3) @(negedge clk);

    chk("if scoreboard drained", 32'(if_q.size()), 32'd0);
    chk("mem scoreboard drained", 32'(mem_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
